// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master blocks: FSM state codes, the SPI mode
// in use, and counter width helpers.
package spi_pkg;

    typedef logic [2:0] spi_state_t;

    localparam spi_state_t ST_IDLE  = 3'd0;
    localparam spi_state_t ST_SETUP = 3'd1;
    localparam spi_state_t ST_SHIFT = 3'd2;
    localparam spi_state_t ST_HOLD  = 3'd3;
    localparam spi_state_t ST_GAP   = 3'd4;

    // Mode 0: clock idles low, data launched on falling edges, sampled on rising.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    function automatic int bit_cnt_width(input int total_bits);
        return $clog2(total_bits + 1);
    endfunction

    function automatic int div_cnt_width(input int clk_div);
        return (clk_div > 1) ? $clog2(clk_div) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period divider for SPI masters: a tick every CLK_DIV cycles while run is
// high, the SPI clock level, and single-cycle strobes ahead of each SCLK edge.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic toggle_en,
    output logic sclk,
    output logic tick,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int DW = div_cnt_width(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    assign tick     = run && (div_cnt == DIV_LAST);
    assign rise_stb = tick && toggle_en && !sclk;
    assign fall_stb = tick && toggle_en && sclk;

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Strobes fire on the cycle whose closing edge moves sclk.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            sclk <= SPI_CPOL;
        end else if (tick && toggle_en) begin
            sclk <= ~sclk;
        end
    end

endmodule

// File: rtl/spi_transmitter.sv
// Mode-0 SPI master transmitter: frames each word as leading zero pad bits then
// the payload MSB first. Optional one-word skid buffer: SPI_TRANSMITTER_SKID_EN.
module spi_transmitter
    import spi_pkg::*;
#(
    parameter int WIDTH      = 10,
    parameter int TOTAL_BITS = 14,
    parameter int CLK_DIV    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             SPI_clk,
    output logic             SPI_Data_out,
    output logic             CS,
    output logic             busy,
    output logic             done
);

    localparam int BW = bit_cnt_width(TOTAL_BITS);
    localparam logic [BW-1:0] BITS_INIT = BW'(TOTAL_BITS);
    localparam logic [BW-1:0] BITS_LAST = BW'(1);

    spi_state_t            state;
    logic [TOTAL_BITS-1:0] shreg;
    logic [TOTAL_BITS-1:0] shifted;
    logic [TOTAL_BITS-1:0] load_frame;
    logic [BW-1:0]         bit_cnt;
    logic [WIDTH-1:0]      load_word;

    logic run, toggle_en, tick, rise_stb, fall_stb;
    logic accept, gap_exit, load_direct, load_from_buf;

    assign run       = (state != ST_IDLE);
    assign toggle_en = (state == ST_SETUP) || (state == ST_SHIFT);
    assign busy      = run;
    assign accept    = tx_valid && tx_ready;
    assign gap_exit  = (state == ST_GAP) && tick;

    // Zero-extension supplies the leading pad bits.
    assign load_frame = TOTAL_BITS'(load_word);
    assign shifted    = shreg << 1;

`ifdef SPI_TRANSMITTER_SKID_EN
    logic             buf_full;
    logic [WIDTH-1:0] buf_data;
    logic             buf_wr;

    assign tx_ready      = !reset && !buf_full;
    assign load_from_buf = gap_exit && buf_full;
    // A word arriving on the GAP exit edge bypasses the buffer.
    assign load_direct   = accept && ((state == ST_IDLE) || (gap_exit && !buf_full));
    assign buf_wr        = accept && !load_direct;
    assign load_word     = load_from_buf ? buf_data : tx_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else if (load_from_buf) begin
            buf_full <= 1'b0;
        end else if (buf_wr) begin
            buf_full <= 1'b1;
            buf_data <= tx_data;
        end
    end
`else
    assign tx_ready      = !reset && (state == ST_IDLE);
    assign load_from_buf = 1'b0;
    assign load_direct   = accept;
    assign load_word     = tx_data;
`endif

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .toggle_en (toggle_en),
        .sclk      (SPI_clk),
        .tick      (tick),
        .rise_stb  (rise_stb),
        .fall_stb  (fall_stb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            CS           <= 1'b1;
            SPI_Data_out <= 1'b0;
            done         <= 1'b0;
            shreg        <= '0;
            bit_cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_direct) begin
                        state        <= ST_SETUP;
                        CS           <= 1'b0;
                        shreg        <= load_frame;
                        SPI_Data_out <= load_frame[TOTAL_BITS-1];
                        bit_cnt      <= BITS_INIT;
                    end
                end
                ST_SETUP: begin
                    if (rise_stb) begin
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Data moves only on falling edges so it is stable at each rise.
                    if (fall_stb) begin
                        shreg        <= shifted;
                        SPI_Data_out <= shifted[TOTAL_BITS-1];
                        bit_cnt      <= bit_cnt - 1'b1;
                        if (bit_cnt == BITS_LAST) begin
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        state        <= ST_GAP;
                        CS           <= 1'b1;
                        done         <= 1'b1;
                        SPI_Data_out <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        if (load_from_buf || load_direct) begin
                            state        <= ST_SETUP;
                            CS           <= 1'b0;
                            shreg        <= load_frame;
                            SPI_Data_out <= load_frame[TOTAL_BITS-1];
                            bit_cnt      <= BITS_INIT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    CS    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_transmitter.sv
// Scoreboard bench for spi_transmitter: expected frames are queued at issue time
// and a negedge monitor rebuilds each frame from rising SPI_clk edges.
module tb_spi_transmitter;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, spi_clk, dout, cs, busy, done;

    logic [7:0] tx_data2;
    logic       tx_valid2;
    logic       tx_ready2, spi_clk2, dout2, cs2, busy2, done2;

    always #5 clk = ~clk;

    spi_transmitter #(.WIDTH(10), .TOTAL_BITS(14), .CLK_DIV(2)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .SPI_clk(spi_clk), .SPI_Data_out(dout),
        .CS(cs), .busy(busy), .done(done)
    );

    spi_transmitter #(.WIDTH(8), .TOTAL_BITS(8), .CLK_DIV(1)) dut2 (
        .clk(clk), .reset(reset), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .SPI_clk(spi_clk2), .SPI_Data_out(dout2),
        .CS(cs2), .busy(busy2), .done(done2)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard for the main instance.
    logic [13:0] exp_q[$];
    int          gaps[$];
    int          done_cnt = 0;
    logic [13:0] rx_bits = '0;
    int          rx_n = 0;
    logic        sclk_q = 1'b0;
    logic        cs_q = 1'b1;
    int          hi_cnt = 0;

    always @(negedge clk) begin
        if (cs_q === 1'b1 && cs === 1'b0) begin
            gaps.push_back(hi_cnt);
            rx_bits = '0;
            rx_n    = 0;
        end
        if (cs === 1'b1) hi_cnt++;
        else             hi_cnt = 0;
        if (cs === 1'b0 && spi_clk === 1'b1 && sclk_q === 1'b0) begin
            rx_bits = {rx_bits[12:0], dout};
            rx_n++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                logic [13:0] e;
                e = exp_q.pop_front();
                chk("frame_bits", rx_bits, e);
                chk("frame_len", rx_n, 14);
            end
        end
        sclk_q = spi_clk;
        cs_q   = cs;
    end

    logic cs_s[0:127], done_s[0:127], rdy_s[0:127], sclk_s[0:127], busy_s[0:127];

    task automatic capture(input int n_max);
        for (int n = 1; n <= n_max; n++) begin
            @(negedge clk);
            cs_s[n] = cs; done_s[n] = done; rdy_s[n] = tx_ready;
            sclk_s[n] = spi_clk; busy_s[n] = busy;
        end
    endtask

    task automatic send(input logic [9:0] d);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_ready) begin ok = 1; break; end
        end
        if (!ok) chk("ready_timeout", 0, 1);
        tx_valid = 1'b1;
        tx_data  = d;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_cnt >= target) begin ok = 1; break; end
        end
        if (!ok) chk("done_timeout", done_cnt, target);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, g0, r;
        logic prev;
        logic [15:0] patt;
        logic [7:0]  bits2;
        int          nb2;

        reset = 1'b1; tx_valid = 1'b0; tx_data = '0;
        tx_valid2 = 1'b0; tx_data2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_cs", cs, 1);
        chk("rst_sclk", spi_clk, 0);
        chk("rst_dout", dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", tx_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", tx_ready, 1);

        // Single word: 10'h2A5 -> 0000_1010100101 with exact frame timing.
        exp_q.push_back(14'h02A5);
        send(10'h2A5);
        capture(62);
        chk("t1_cs_fall", cs_s[1], 0);
        chk("t1_busy", busy_s[1], 1);
        chk("t1_setup_sclk", sclk_s[2], 0);
        chk("t1_rise0", sclk_s[3], 1);
        chk("t1_fall0", sclk_s[5], 0);
        chk("t1_cs_low_end", cs_s[58], 0);
        chk("t1_cs_rise", cs_s[59], 1);
        chk("t1_done_pre", done_s[58], 0);
        chk("t1_done", done_s[59], 1);
        chk("t1_done_post", done_s[60], 0);
        chk("t1_gap_busy", busy_s[60], 1);
        chk("t1_idle_busy", busy_s[61], 0);
        chk("t1_ready_back", rdy_s[61], 1);
`ifdef SPI_TRANSMITTER_SKID_EN
        chk("t1_ready_midframe", rdy_s[30], 1);
`else
        chk("t1_ready_gap", rdy_s[60], 0);
        chk("t1_ready_midframe", rdy_s[30], 0);
`endif

        // All ones then all zeros, second word sent as soon as ready.
        g0 = gaps.size();
        d0 = done_cnt;
        exp_q.push_back(14'h03FF);
        exp_q.push_back(14'h0000);
        send(10'h3FF);
        send(10'h000);
        wait_done(d0 + 2);
        chk("t2_gap_min", (gaps.size() > g0 + 1) ? ((gaps[g0+1] >= 2) ? 1 : 0) : 0, 1);

        // Input changes during a frame must not affect the word in flight.
        d0 = done_cnt;
        exp_q.push_back(14'h0155);
        send(10'h155);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            tx_data = 10'($urandom);
`ifndef SPI_TRANSMITTER_SKID_EN
            tx_valid = 1'b1;
`endif
        end
        tx_valid = 1'b0;
        wait_done(d0 + 1);
        repeat (20) @(negedge clk);
        chk("t4_no_extra_cs", cs, 1);
        chk("t4_one_frame", done_cnt, d0 + 1);

        // Abort at the 6th rising SPI_clk edge.
        d0 = done_cnt;
        send(10'h0F0);
        r = 0; prev = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (spi_clk && !prev) r++;
            prev = spi_clk;
            if (r == 6) break;
        end
        chk("t3_reached_rise6", r, 6);
        reset = 1'b1;
        @(negedge clk);
        chk("t3_abort_cs", cs, 1);
        chk("t3_abort_sclk", spi_clk, 0);
        chk("t3_abort_dout", dout, 0);
        chk("t3_abort_busy", busy, 0);
        chk("t3_ready_in_rst", tx_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t3_ready_after", tx_ready, 1);
        repeat (70) @(negedge clk);
        chk("t3_no_done", done_cnt, d0);

        // CLK_DIV=1, 8-bit frame, 8'hA5.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_ready2) break;
        end
        tx_valid2 = 1'b1;
        tx_data2  = 8'hA5;
        @(posedge clk);
        #1 tx_valid2 = 1'b0;
        patt = '0; bits2 = '0; nb2 = 0; prev = 1'b0;
        for (int n = 1; n <= 19; n++) begin
            @(negedge clk);
            if (n == 1) chk("t5_cs_fall", cs2, 0);
            if (n >= 2 && n <= 17) patt[n-2] = spi_clk2;
            if (spi_clk2 && !prev) begin bits2 = {bits2[6:0], dout2}; nb2++; end
            prev = spi_clk2;
            if (n == 17) chk("t5_done_pre", done2, 0);
            if (n == 18) chk("t5_done", done2, 1);
        end
        chk("t5_sclk_toggle", patt, 16'h5555);
        chk("t5_bits", bits2, 8'hA5);
        chk("t5_nbits", nb2, 8);

`ifdef SPI_TRANSMITTER_SKID_EN
        begin
            logic [9:0] w[3];
            int acc[3];
            int i;
            w[0] = 10'h111; w[1] = 10'h2AA; w[2] = 10'h0F5;
            repeat (5) @(negedge clk);
            g0 = gaps.size();
            d0 = done_cnt;
            i = 0;
            tx_valid = 1'b1;
            tx_data  = w[0];
            for (int t = 0; t < 400 && i < 3; t++) begin
                if (tx_ready) begin
                    exp_q.push_back(14'(w[i]));
                    @(posedge clk);
                    #1;
                    acc[i] = cyc;
                    i++;
                    if (i < 3) tx_data = w[i];
                    else       tx_valid = 1'b0;
                end
                @(negedge clk);
            end
            tx_valid = 1'b0;
            chk("t6_all_accepted", i, 3);
            wait_done(d0 + 3);
            chk("t6_acc2_next_edge", acc[1] - acc[0], 1);
            chk("t6_acc3_period", acc[2] - acc[0], 61);
            chk("t6_gap1", (gaps.size() > g0 + 1) ? gaps[g0+1] : -1, 2);
            chk("t6_gap2", (gaps.size() > g0 + 2) ? gaps[g0+2] : -1, 2);
        end
`endif

        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
